ram1_bus_ctrl: RTL and testbench

Sequencer for the shared Ram1 data bus of zzcpu. It takes single-word load/store requests from the CPU memory stage and turns them into correctly ordered strobes on the Ram1 SRAM or the UART, which share Ram1Data. It also serves the UART status register. It owns every Ram1/UART pin and is the only driver of Ram1Data.

---
 rtl/ram1_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ram1_bus_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram1_bus_ctrl.sv
// ==== ram1_bus_ctrl : Ram1 SRAM / UART shared-bus sequencer  (rev 1.0) ====
`default_nettype none

module ram1_bus_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int          RD_WAIT        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        wrn,
  output logic        rdn
);

  typedef enum logic [3:0] {
    IDLE, STAT, M_RD, M_WR1, M_WR2, M_WR3,
    U_RD1, U_RD2, U_WR1, U_WR2, U_WAIT_TBRE, U_WAIT_TSRE, DONE
  } state_t;

  localparam logic [1:0] RD_LAST = 2'(RD_WAIT);

  state_t      r_state;
  logic [1:0]  r_rd_cnt;
  logic        r_drive;
  logic [15:0] r_dout;

  assign Ram1Data = r_drive ? r_dout : 16'hzzzz;

  // Strobes are registered on the edge that enters each state, so the pins
  // always reflect the state currently held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd_cnt <= 2'd0;
      r_drive  <= 1'b0;
      r_dout   <= 16'h0000;
      rdata    <= 16'h0000;
      ack      <= 1'b0;
      busy     <= 1'b0;
      Ram1Addr <= 18'h00000;
      Ram1OE   <= 1'b1;
      Ram1WE   <= 1'b1;
      Ram1EN   <= 1'b1;
      wrn      <= 1'b1;
      rdn      <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            Ram1Addr <= {2'b00, addr};
            busy     <= 1'b1;
            if (addr == UART_STAT_ADDR) begin
              r_state <= STAT;
            end else if (addr == UART_DATA_ADDR) begin
              if (we) begin
                r_state <= U_WR1;
                r_drive <= 1'b1;
                r_dout  <= {8'h00, wdata[7:0]};
                wrn     <= 1'b0;
              end else begin
                r_state <= U_RD1;
                rdn     <= 1'b0;
              end
            end else begin
              Ram1EN <= 1'b0;
              if (we) begin
                r_state <= M_WR1;
                r_drive <= 1'b1;
                r_dout  <= wdata;
              end else begin
                r_state  <= M_RD;
                Ram1OE   <= 1'b0;
                r_rd_cnt <= 2'd0;
              end
            end
          end
        end
        STAT: begin
          rdata   <= {14'b0, data_ready, tbre & tsre};
          ack     <= 1'b1;
          r_state <= DONE;
        end
        M_RD: begin
          if (r_rd_cnt == RD_LAST) begin
            rdata   <= Ram1Data;
            Ram1OE  <= 1'b1;
            Ram1EN  <= 1'b1;
            ack     <= 1'b1;
            r_state <= DONE;
          end else begin
            r_rd_cnt <= r_rd_cnt + 2'd1;
          end
        end
        M_WR1: begin
          Ram1WE  <= 1'b0;
          r_state <= M_WR2;
        end
        M_WR2: begin
          Ram1WE  <= 1'b1;
          r_state <= M_WR3;
        end
        M_WR3: begin
          r_drive <= 1'b0;
          Ram1EN  <= 1'b1;
          ack     <= 1'b1;
          r_state <= DONE;
        end
        // The UART only presents its byte while rdn is low, so capture on
        // the edge that releases rdn.
        U_RD1: begin
          rdn     <= 1'b1;
          rdata   <= {8'h00, Ram1Data[7:0]};
          r_state <= U_RD2;
        end
        U_RD2: begin
          ack     <= 1'b1;
          r_state <= DONE;
        end
        U_WR1: begin
          wrn     <= 1'b1;
          r_state <= U_WR2;
        end
        U_WR2: begin
          r_drive <= 1'b0;
          r_state <= U_WAIT_TBRE;
        end
        U_WAIT_TBRE: begin
          if (tbre) r_state <= U_WAIT_TSRE;
        end
        U_WAIT_TSRE: begin
          if (tsre) begin
            ack     <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram1_bus_ctrl.sv
// ==== tb_ram1_bus_ctrl : randomized bench for ram1_bus_ctrl with SRAM/UART bus models  (rev 1.0) ====
`default_nettype none

module tb_ram1_bus_ctrl;
  localparam int RD_WAIT = 1;
  localparam logic [15:0] UDATA = 16'hBF00;
  localparam logic [15:0] USTAT = 16'hBF01;

  logic        clk = 1'b0;
  logic        rst, req, we, data_ready, tbre, tsre;
  logic [15:0] addr, wdata, rdata;
  logic        ack, busy, Ram1OE, Ram1WE, Ram1EN, wrn, rdn;
  logic [17:0] Ram1Addr;
  wire  [15:0] Ram1Data;

  always #5 clk = ~clk;

  ram1_bus_ctrl #(.UART_DATA_ADDR(UDATA), .UART_STAT_ADDR(USTAT), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data),
    .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN), .data_ready(data_ready),
    .tbre(tbre), .tsre(tsre), .wrn(wrn), .rdn(rdn)
  );

  // External devices: SRAM answers while OE/EN low, UART puts junk in the high byte
  logic [15:0] sram [0:65535];
  logic [7:0]  rx_byte;
  assign Ram1Data = (!Ram1OE && !Ram1EN) ? sram[Ram1Addr[15:0]] :
                    (!rdn ? {8'hC3, rx_byte} : 16'hzzzz);

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus monitor
  int          we_lo, wrn_lo, en_lo, acks_txn, acks_total, conflicts, busy_bad;
  logic [17:0] we_addr;
  logic [15:0] we_data, tx_data;
  bit          in_txn;

  always @(negedge clk) begin
    if (ack) begin acks_total++; acks_txn++; end
    if (!Ram1WE) begin
      we_lo++; we_addr = Ram1Addr; we_data = Ram1Data;
      if (!Ram1EN) sram[Ram1Addr[15:0]] = Ram1Data;
    end
    if (!wrn) begin wrn_lo++; tx_data = Ram1Data; end
    if (!Ram1EN) en_lo++;
    if ((!Ram1EN || !Ram1OE || !Ram1WE) && (!wrn || !rdn)) conflicts++;
    if (in_txn && !busy) busy_bad++;
  end

  // Reference model: memory contents and last load result
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rdata;
  int          ntxn = 0;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  function automatic logic [15:0] junk_addr();
    case ($urandom_range(0, 2))
      0: return UDATA;
      1: return USTAT;
      default: return 16'h0900;
    endcase
  endfunction

  // Entered mid-cycle with the DUT in IDLE or DONE; the next edge must not accept.
  task automatic run_txn(input bit hold, input bit w, input logic [15:0] a,
                         input logic [15:0] d, input int s1, input int s2);
    int n, lat;
    bit is_stat, is_uart, is_mwr;
    is_stat = (a == USTAT);
    is_uart = (a == UDATA);
    is_mwr  = w && !is_stat && !is_uart;
    ntxn++;
    if (hold) begin
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
    end else begin
      req = 1'b0;
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = d;
    end
    chk("idle_busy_ack", {busy, ack}, 2'b00);
    we_lo = 0; wrn_lo = 0; en_lo = 0; acks_txn = 0; conflicts = 0; busy_bad = 0;
    if (is_stat) begin
      lat = 1; exp_rdata = {14'b0, data_ready, tbre & tsre};
    end else if (is_uart) begin
      lat = w ? 4 + s1 + s2 : 2;
      if (!w) exp_rdata = {8'h00, rx_byte};
    end else if (w) begin
      lat = 3; ref_mem[int'(a)] = d;
    end else begin
      lat = RD_WAIT + 1; exp_rdata = ref_rd(a);
    end
    @(posedge clk); #1;
    in_txn = 1'b1;
    n = 0;
    while (!ack && n < 100) begin
      if (is_uart && w) begin
        tbre = (n >= 2 + s1);
        tsre = (n >= 3 + s1 + s2);
      end
      req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      addr = junk_addr(); wdata = 16'($urandom);
      @(posedge clk); n++; #1;
    end
    chk("latency", n, lat);
    req = 1'b0;
    @(negedge clk); #1;
    in_txn = 1'b0;
    chk("rdata", rdata, exp_rdata);
    chk("ack_once", acks_txn, 1);
    chk("busy_span", busy_bad, 0);
    chk("strobe_excl", conflicts, 0);
    chk("we_pulses", we_lo, is_mwr ? 1 : 0);
    chk("wrn_pulses", wrn_lo, (is_uart && w) ? 1 : 0);
    if (is_uart || is_stat) chk("en_uart", en_lo, 0);
    if (is_mwr) begin
      chk("wr_addr", we_addr, {2'b00, a});
      chk("wr_data", we_data, d);
    end
    if (is_uart && w) chk("tx_data", tx_data, {8'h00, d[7:0]});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = dflt(16'(i));
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0;
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1; rx_byte = 8'h00;
    exp_rdata = 16'h0000; in_txn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {Ram1OE, Ram1WE, Ram1EN, wrn, rdn, ack, busy}, 7'b1111100);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_addr", Ram1Addr, 18'h0);
    rst = 1'b0;

    run_txn(1'b0, 1'b1, 16'h0800, 16'h1234, 0, 0);
    run_txn(1'b1, 1'b0, 16'h0800, 16'h0000, 0, 0);
    run_txn(1'b0, 1'b1, UDATA, 16'h0041, 3, 2);
    rx_byte = 8'h5A; data_ready = 1'b1;
    run_txn(1'b0, 1'b0, UDATA, 16'h0000, 0, 0);
    tbre = 1'b1; tsre = 1'b0;
    run_txn(1'b0, 1'b0, USTAT, 16'h0000, 0, 0);
    tsre = 1'b1;
    run_txn(1'b1, 1'b0, USTAT, 16'h0000, 0, 0);

    // Abort a store while WE is low
    req = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 16'h3000; wdata = 16'hBEEF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_low", Ram1WE, 1'b0);
    chk("abort_bus", Ram1Data, 16'hBEEF);
    begin
      int a0;
      a0 = acks_total;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_we_high", Ram1WE, 1'b1);
      chk("abort_bus_free", (Ram1Data === 16'hzzzz) || (Ram1Data === 16'h0000), 1'b1);
      chk("abort_idle", {Ram1EN, busy, ack}, 3'b100);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_ack", acks_total, a0);
      exp_rdata = 16'h0000;
      chk("abort_rdata", rdata, exp_rdata);
    end

    for (int t = 0; t < 200; t++) begin
      bit          h, w;
      logic [15:0] a, d;
      int          s1, s2;
      h = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      d = 16'($urandom);
      s1 = 0; s2 = 0;
      data_ready = 1'($urandom_range(0, 1));
      tbre = 1'($urandom_range(0, 1));
      tsre = 1'($urandom_range(0, 1));
      rx_byte = 8'($urandom);
      case ($urandom_range(0, 6))
        0:       begin w = 1'b1; a = 16'h0800 + 16'($urandom_range(0, 7)); end
        1, 5:    begin w = 1'b0; a = 16'h0800 + 16'($urandom_range(0, 7)); end
        2:       begin w = 1'b1; a = UDATA; s1 = $urandom_range(0, 3); s2 = $urandom_range(0, 3); end
        3:       begin w = 1'b0; a = UDATA; end
        4:       begin w = 1'b0; a = USTAT; end
        default: begin w = 1'($urandom_range(0, 1)); a = ($urandom_range(0, 1) != 0) ? 16'hBF02 : 16'hBEFF; end
      endcase
      run_txn(h, w, a, d, s1, s2);
    end

    chk("total_acks", acks_total, ntxn);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
